iterative_divider: RTL

- Sequential unsigned restoring divider: the inverse operation to the MAC datapath's multiplier tree.
- Produces one quotient bit per clock.
- Sits beside the MAC unit for normalisation and averaging of accumulated results.
- Start/done handshake; results held stable between operations.

---
 rtl/iterative_divider_pkg.sv | 10 +
 rtl/iterative_divider_step.sv | 27 ++
 rtl/iterative_divider.sv | 134 +++++++++++++
 3 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings.
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iterative_divider_step.sv
// One unsigned restoring-division step: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The partial remainder is one bit wider than the operands: rem_in can
    // have its MSB set when the divisor is above 2^(WIDTH-1), and dropping
    // that bit would corrupt the compare.
    logic [WIDTH:0] w_partial;
    logic [WIDTH:0] w_diff;

    assign w_partial = {rem_in, bit_in};
    assign w_diff    = w_partial - {1'b0, divisor};

    // rem_in < divisor bounds partial below 2*divisor, so the difference always
    // fits in WIDTH bits when non-negative and its top bit is a clean borrow.
    assign q_bit   = ~w_diff[WIDTH];
    assign rem_out = q_bit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];

endmodule

// File: rtl/iterative_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/ready/done handshake. Results are held until the next done pulse.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;       // restoring steps already completed
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;           // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] r_divisor;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_calc;
    logic [WIDTH-1:0] w_q_src;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_div;
    logic [WIDTH-1:0] w_rem_out;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_next;

    // The single step unit serves two masters: while calculating it iterates on
    // the registered state; on an accept edge it performs the first step
    // straight from the input operands, so WIDTH steps fit in WIDTH-1 CALC
    // cycles plus the accept edge.
    assign w_calc     = (r_state == ST_CALC);
    assign w_q_src    = w_calc ? r_q       : dividend;
    assign w_step_rem = w_calc ? r_rem     : '0;
    assign w_step_div = w_calc ? r_divisor : divisor;
    assign w_q_next   = {w_q_src[WIDTH-2:0], w_q_bit};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (w_step_rem),
        .bit_in  (w_q_src[WIDTH-1]),
        .divisor (w_step_div),
        .rem_out (w_rem_out),
        .q_bit   (w_q_bit)
    );

    // FSM, datapath and registered outputs in one sequential process.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is plain flops (no memories), so everything is reset;
        // an asynchronous reset also aborts an operation without a done pulse.
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_divisor     <= '0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                    if (start) begin
                        r_divisor <= divisor;
                        if (divisor == '0) begin
                            // Divide-by-zero finishes at once with a defined result.
                            r_state       <= ST_DONE;
                            r_done        <= 1'b1;
                            r_quotient    <= '1;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                            r_ready <= 1'b0;
                            r_rem   <= w_rem_out;
                            r_q     <= w_q_next;
                            r_count <= CNT_W'(1);
                        end
                    end
                end

                ST_CALC: begin
                    r_rem   <= w_rem_out;
                    r_q     <= w_q_next;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_CNT) begin
                        // This edge performs the WIDTH-th step: publish it.
                        r_state       <= ST_DONE;
                        r_ready       <= 1'b1;
                        r_done        <= 1'b1;
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_rem_out;
                        r_div_by_zero <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
